// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder stage plus a carry flop,
// processing one bit per clock, LSB first, with a registered result.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Counter is at least one bit wide so WIDTH=1 still compares cleanly.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] opa_sr;
    logic [WIDTH-1:0] opb_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             s;
    logic             c_nxt;
    logic             last;
    logic             load;

    assign s     = opa_sr[0] ^ opb_sr[0] ^ c;
    assign c_nxt = (opa_sr[0] & opb_sr[0]) | (opa_sr[0] & c) | (opb_sr[0] & c);
    assign last  = (cnt == CW'(WIDTH - 1));
    assign load  = start && (state != SHIFT);

    // New sum bit enters at the MSB while the result register shifts right.
    always_comb begin
        res_nxt = res_sr >> 1;
        res_nxt[WIDTH-1] = s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is honoured in IDLE and DONE only.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, bit-serial add, and result publication on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_sr    <= '0;
            opb_sr    <= '0;
            res_sr    <= '0;
            cnt       <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (load) begin
            opa_sr <= a;
            opb_sr <= b;
            res_sr <= '0;
            cnt    <= '0;
            c      <= 1'b0;
        end else if (state == SHIFT) begin
            opa_sr <= opa_sr >> 1;
            opb_sr <= opb_sr >> 1;
            res_sr <= res_nxt;
            c      <= c_nxt;
            cnt    <= cnt + 1'b1;
            if (last) begin
                sum       <= res_nxt;
                carry_out <= c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random
// operands against an arithmetic reference (a+b), WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, co8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, co1;
    logic [0:0] sum1;

    int checks = 0;
    int passes = 0;
    logic [8:0] prev8 = '0;
    logic [1:0] prev1 = '0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One WIDTH=8 operation. pre: start/operands already driven.
    // inj: re-assert start with new operands mid-operation.
    // chain: hold start through the done cycle with next operands.
    task automatic run8(input logic [7:0] xa, input logic [7:0] xb,
                        input bit pre, input bit inj, input bit chain,
                        input logic [7:0] na, input logic [7:0] nb);
        logic [8:0] exp;
        int n;
        exp = {1'b0, xa} + {1'b0, xb};
        if (!pre) begin
            @(negedge clk);
            a8 = xa; b8 = xb; start8 = 1'b1;
        end
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        n = 0;
        while (!done8 && n < 40) begin
            chk("busy", busy8, 1);
            chk("hold", {co8, sum8}, prev8);
            if (inj && n == 2) begin
                start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
            end else if (inj && n == 3) begin
                start8 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk("latency8", n, 8);
        chk("done8", done8, 1);
        chk("busy_d8", busy8, 0);
        chk("result8", {co8, sum8}, exp);
        prev8 = exp;
        if (chain) begin
            a8 = na; b8 = nb; start8 = 1'b1;
        end else begin
            @(negedge clk);
            chk("pulse8", done8, 0);
        end
    endtask

    task automatic run1(input logic xa, input logic xb);
        logic [1:0] exp;
        int n;
        exp = {1'b0, xa} + {1'b0, xb};
        @(negedge clk);
        a1 = xa; b1 = xb; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        a1 = ~a1; b1 = ~b1;
        n = 0;
        while (!done1 && n < 10) begin
            chk("busy1", busy1, 1);
            chk("hold1", {co1, sum1}, prev1);
            @(negedge clk);
            n++;
        end
        chk("latency1", n, 1);
        chk("result1", {co1, sum1}, exp);
        prev1 = exp;
        @(negedge clk);
        chk("pulse1", done1, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_res8", {co8, sum8}, 0);
        chk("rst_res1", {co1, sum1}, 0);
        rst = 1'b0;

        run8(8'h35, 8'h4A, 0, 0, 0, 0, 0);
        run8(8'hFF, 8'h01, 0, 0, 0, 0, 0);
        run8(8'h80, 8'h80, 0, 1, 0, 0, 0);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy8, 0);
        chk("arst_done", done8, 0);
        chk("arst_res", {co8, sum8}, 0);
        prev8 = '0;
        prev1 = '0;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) n++;
        end
        chk("no_done", n, 0);

        run8(8'h12, 8'h34, 0, 0, 0, 0, 0);
        run8(8'hC0, 8'h55, 0, 0, 1, 8'h0F, 8'h01);
        run8(8'h0F, 8'h01, 1, 0, 0, 0, 0);

        for (int i = 0; i < 25; i++)
            run8(8'($urandom), 8'($urandom), 0, 0, 0, 0, 0);

        run1(1'b1, 1'b1);
        run1(1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            run1(1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
